// File: rtl/axi4_reader.sv
// AXI4 frame reader: walks a frame buffer in fixed 64-beat INCR bursts and
// streams the words out through a first-word-fall-through FIFO.
module axi4_reader #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int FRAME_BYTES    = 153600,
  parameter int FIFO_DEPTH     = 256
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic                      RVALID,
  input  logic                      RLAST,
  input  logic [1:0]                RRESP,
  output logic                      RREADY,
  output logic [AXI_DATA_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_frame_last,
  output logic                      reader_done,
  output logic                      rresp_err,
  output logic [1:0]                state
);
  localparam int BURST_BEATS = 64;
  localparam int BURST_BYTES = BURST_BEATS * (AXI_DATA_WIDTH / 8);
  localparam int FRAME_WORDS = FRAME_BYTES / (AXI_DATA_WIDTH / 8);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(FRAME_WORDS);
  localparam logic [AXI_ADDR_WIDTH-1:0] FRAME_OFF  = AXI_ADDR_WIDTH'(FRAME_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_OFF  = AXI_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [PW:0]               FREE_LIM   = PW1'(FIFO_DEPTH - BURST_BEATS);
  localparam logic [PW:0]               DEPTH_L    = PW1'(FIFO_DEPTH);
  localparam logic [CW-1:0]             LAST_WORD  = CW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR_SEND = 2'd1, DATA_RECV = 2'd2, FRAME_END = 2'd3} state_t;
  state_t cur, nxt;

  logic                      fs_d, start_edge, frame_active, discard, discard_now;
  logic                      beat_acc, burst_end, push, pop, free_ok, full;
  logic [AXI_ADDR_WIDTH-1:0] base, offset, next_off;
  logic [5:0]                beat_cnt;
  logic [PW:0]               wr_ptr, rd_ptr, occ;
  logic [CW-1:0]             out_cnt;
  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  assign ARLEN   = 8'd63;
  assign ARSIZE  = 3'b011;
  assign ARBURST = 2'b01;
  assign ARCACHE = 4'b0011;
  assign ARPROT  = 3'b000;

  assign state        = cur;
  assign start_edge   = frame_start & ~fs_d;
  assign RREADY       = (cur == DATA_RECV);
  assign beat_acc     = RVALID & RREADY;
  assign burst_end    = beat_acc & RLAST;
  // Beats of a burst issued for the previous frame are drained but never stored.
  assign discard_now  = discard | start_edge;
  assign next_off     = offset + BURST_OFF;
  assign occ          = wr_ptr - rd_ptr;
  assign full         = (occ == DEPTH_L);
  assign free_ok      = (occ <= FREE_LIM);
  assign push         = beat_acc & ~discard_now;
  assign m_valid      = (occ != '0) & ~start_edge;
  assign pop          = m_valid & m_ready;
  assign m_data       = mem[rd_ptr[PW-1:0]];
  assign m_frame_last = m_valid & (out_cnt == LAST_WORD);
  assign reader_done  = (cur == FRAME_END);

  // State register
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) cur <= IDLE;
    else     cur <= nxt;

  // Next-state: one burst in flight at a time, launched only when it fits in the FIFO
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:      if (frame_active && !start_edge && offset < FRAME_OFF && free_ok) nxt = ADDR_SEND;
      ADDR_SEND: if (ARVALID && ARREADY) nxt = DATA_RECV;
      DATA_RECV: if (burst_end) nxt = (!discard_now && next_off == FRAME_OFF) ? FRAME_END : IDLE;
      FRAME_END: nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Frame bookkeeping: base/offset latch and the drop-in-flight-burst flag
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      fs_d <= 1'b0; frame_active <= 1'b0; base <= '0; offset <= '0; discard <= 1'b0;
    end else begin
      fs_d <= frame_start;
      if (start_edge) begin
        frame_active <= 1'b1;
        base         <= FRAME_BASE_ADDR;
        offset       <= '0;
        discard      <= (cur == ADDR_SEND) | ((cur == DATA_RECV) & ~burst_end);
      end else if (burst_end) begin
        discard <= 1'b0;
        if (!discard) offset <= next_off;
      end
    end

  // Address channel: ARADDR loaded on launch and held until the handshake
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      ARVALID <= 1'b0; ARADDR <= '0;
    end else if (cur == IDLE && nxt == ADDR_SEND) begin
      ARVALID <= 1'b1; ARADDR <= base + offset;
    end else if (ARVALID && ARREADY) begin
      ARVALID <= 1'b0;
    end

  // Per-burst beat count and sticky response error. The count follows the
  // burst actually on the bus, so it is not cleared by a new frame edge:
  // a dropped burst still ends on its own RLAST without a false error.
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      beat_cnt <= '0; rresp_err <= 1'b0;
    end else if (beat_acc) begin
      beat_cnt <= RLAST ? 6'd0 : beat_cnt + 6'd1;
      if (RRESP != 2'b00 || (RLAST && beat_cnt != 6'd63)) rresp_err <= 1'b1;
    end

  // FIFO pointers; a frame edge flushes and beats any same-cycle push
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      wr_ptr <= '0; rd_ptr <= '0;
    end else if (start_edge) begin
      wr_ptr <= '0; rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end

  // FIFO storage
  always_ff @(posedge clk_100Mhz)
    if (push) mem[wr_ptr[PW-1:0]] <= RDATA;

  // Output word position within the frame, drives m_frame_last
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst)             out_cnt <= '0;
    else if (start_edge) out_cnt <= '0;
    else if (pop)        out_cnt <= (out_cnt == LAST_WORD) ? '0 : out_cnt + 1'b1;

  // The launch-time space check must make a push into a full FIFO impossible
  assert property (@(posedge clk_100Mhz) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_axi4_reader.sv
// Bench for axi4_reader: randomized AXI slave plus a frame-level model of the
// expected address sequence and output word stream.
module tb_axi4_reader;
  localparam int FB = 153600;
  localparam int FW = FB / 8;

  logic        clk_100Mhz = 1'b0;
  logic        rst = 1'b1, frame_start = 1'b0;
  logic [31:0] FRAME_BASE_ADDR = '0;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY = 1'b0;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic [63:0] RDATA = '0;
  logic        RVALID = 1'b0, RLAST = 1'b0;
  logic [1:0]  RRESP = 2'b00;
  logic        RREADY;
  logic [63:0] m_data;
  logic        m_valid, m_ready = 1'b1, m_frame_last, reader_done, rresp_err;
  logic [1:0]  state;

  axi4_reader dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .frame_start(frame_start), .FRAME_BASE_ADDR(FRAME_BASE_ADDR),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .RDATA(RDATA), .RVALID(RVALID),
    .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_frame_last(m_frame_last), .reader_done(reader_done),
    .rresp_err(rresp_err), .state(state)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: each 64-bit word is a function of its byte address
  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  // Frame model: expected next AR offset and next output word index
  logic [31:0] exp_base = '0;
  int          exp_off = 0, pop_idx = 0, pops = 0, last_cnt = 0, done_cnt = 0;
  int          ar_cnt = 0, ar_hi = 0, last_hi = 0;
  logic [31:0] ar_hold = '0, last_araddr = '0;
  logic        held_v = 1'b0;
  logic [63:0] held_d = '0;

  // Slave model state
  logic [31:0] bq[$];
  int          beat = 0, ar_wait = 0, ar_delay = 0, r_beats = 0, err_seen = 0;
  bit          r_rand = 1'b0;
  int          mr_mode = 0;
  logic [31:0] err_addr = '1, sa;
  logic        s_ar_hs = 1'b0, s_r_hs = 1'b0;
  logic [31:0] s_araddr = '0;

  // Monitor: samples mid-cycle, checks addresses and the output stream
  always @(negedge clk_100Mhz) begin
    s_ar_hs  = ARVALID && ARREADY;
    s_r_hs   = RVALID && RREADY;
    s_araddr = ARADDR;
    if (rst) begin
      held_v = 1'b0; ar_hi = 0; pop_idx = 0; exp_off = 0;
    end else begin
      if (held_v && m_valid) chk("m_data_hold", m_data, held_d);
      held_v = m_valid && !m_ready;
      held_d = m_data;
      if (m_valid && m_ready) begin
        chk("m_data", m_data, word_of(exp_base + 32'(pop_idx * 8)));
        chk("m_frame_last", m_frame_last, 64'(pop_idx == FW - 1));
        if (m_frame_last) last_cnt++;
        pop_idx = (pop_idx == FW - 1) ? 0 : pop_idx + 1;
        pops++;
      end
      if (reader_done) done_cnt++;
      if (ARVALID) begin
        if (ar_hi > 0) chk("araddr_stable", ARADDR, ar_hold);
        ar_hold = ARADDR;
        ar_hi++;
        if (ARREADY) begin
          chk("araddr", ARADDR, exp_base + 32'(exp_off));
          chk("ar_in_frame", 64'(exp_off < FB), 1);
          exp_off += 512; ar_cnt++; last_hi = ar_hi; ar_hi = 0; last_araddr = ARADDR;
        end
      end
    end
  end

  // AXI slave: answers each AR with 64 beats; optional AR delay and R gaps
  always @(posedge clk_100Mhz) begin
    #1;
    if (rst) begin
      bq.delete(); beat = 0; ar_wait = 0;
      ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = '0;
    end else begin
      if (s_r_hs) begin
        r_beats++;
        if (RRESP != 2'b00) err_seen++;
        if (beat == 63) begin beat = 0; void'(bq.pop_front()); end
        else beat++;
      end
      if (s_ar_hs) begin
        bq.push_back(s_araddr); ar_wait = 0; ARREADY = 1'b0;
      end else if (ARVALID && !ARREADY) begin
        if (ar_wait >= ar_delay) ARREADY = 1'b1;
        else ar_wait++;
      end
      if (bq.size() > 0 && (!r_rand || $urandom_range(0, 3) != 0)) begin
        sa = bq[0] + 32'(beat * 8);
        RVALID = 1'b1; RDATA = word_of(sa); RLAST = (beat == 63);
        RRESP = (sa == err_addr) ? 2'b10 : 2'b00;
      end else begin
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      end
    end
  end

  // Consumer backpressure
  always @(posedge clk_100Mhz) begin
    #1;
    m_ready = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk_100Mhz); #2;
  endtask

  // Raise frame_start now (caller is at posedge+2) and update the model with it
  task automatic start_frame(input logic [31:0] b);
    FRAME_BASE_ADDR = b; frame_start = 1'b1;
    exp_base = b; exp_off = 0; pop_idx = 0;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int t, a0, p0, rec;
    repeat (3) tick();
    chk("rst_state", state, 0);        chk("rst_arvalid", ARVALID, 0);
    chk("rst_araddr", ARADDR, 0);      chk("rst_rready", RREADY, 0);
    chk("rst_m_valid", m_valid, 0);    chk("rst_frame_last", m_frame_last, 0);
    chk("rst_done", reader_done, 0);   chk("rst_rresp_err", rresp_err, 0);
    chk("arlen", ARLEN, 63);           chk("arsize", ARSIZE, 3'b011);
    chk("arburst", ARBURST, 2'b01);    chk("arcache", ARCACHE, 4'b0011);
    chk("arprot", ARPROT, 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("no_frame_no_ar", ar_cnt, 0);

    // Full frame, no backpressure
    start_frame(32'h1000_0000);
    t = 0; while (done_cnt == 0 && t < 40000) begin tick(); t++; end
    chk("A_done_timeout", 64'(t < 40000), 1);
    t = 0; while (pops < FW && t < 2000) begin tick(); t++; end
    repeat (100) tick();
    chk("A_ar_count", ar_cnt, 300);        chk("A_last_araddr", last_araddr, 32'h1002_5600);
    chk("A_words", pops, FW);              chk("A_frame_last_cnt", last_cnt, 1);
    chk("A_done_cnt", done_cnt, 1);        chk("A_word_wrap", pop_idx, 0);
    chk("A_ar_one_cycle", last_hi, 1);     chk("A_idle_arvalid", ARVALID, 0);

    // Consumer stalled: only four bursts fit
    mr_mode = 1; a0 = ar_cnt; p0 = pops;
    start_frame(32'h3000_0000);
    repeat (2000) tick();
    chk("B_bursts_stalled", ar_cnt - a0, 4); chk("B_arvalid_low", ARVALID, 0);
    chk("B_no_pops", pops - p0, 0);          chk("B_m_valid", m_valid, 1);
    chk("B_state_idle", state, 0);

    // Resume with random backpressure, slow ARREADY and gappy R
    ar_delay = 5; r_rand = 1'b1; mr_mode = 2;
    t = 0; while (exp_off < 7 * 512 && t < 5000) begin tick(); t++; end
    chk("B_resume_timeout", 64'(t < 5000), 1);
    chk("B_arvalid_6_cycles", last_hi, 6);

    // New frame edge at beat 30 of burst 10
    t = 0; while (!(exp_off == 11 * 512 && beat == 30 && bq.size() > 0) && t < 20000) begin tick(); t++; end
    chk("C_reach_timeout", 64'(t < 20000), 1);
    rec = r_beats; a0 = ar_cnt;
    start_frame(32'h2000_0000);
    chk("C_m_valid_flushed", m_valid, 0);
    t = 0; while (ar_cnt == a0 && t < 2000) begin tick(); t++; end
    chk("C_ar_timeout", 64'(t < 2000), 1);
    chk("C_dropped_beats", r_beats - rec, 34);
    chk("C_next_araddr", last_araddr, 32'h2000_0000);
    t = 0; while (pop_idx < 64 && t < 5000) begin tick(); t++; end
    chk("C_new_words", 64'(pop_idx >= 64), 1);

    // One bad response beat in burst 2 of the new frame
    chk("D_err_clear", rresp_err, 0);
    err_addr = 32'h2000_0000 + 2 * 512 + 40;
    t = 0; while (err_seen == 0 && t < 10000) begin tick(); t++; end
    chk("D_err_timeout", 64'(t < 10000), 1);
    chk("D_err_set", rresp_err, 1);
    t = 0; while (pop_idx < 4 * 64 && t < 10000) begin tick(); t++; end
    chk("D_flow_continues", 64'(pop_idx >= 4 * 64), 1);
    err_addr = '1; ar_delay = 0;
    t = 0; while (!RREADY && t < 2000) begin tick(); t++; end
    start_frame(32'h4000_0000);
    chk("D_err_sticky", rresp_err, 1);
    r_rand = 1'b0; mr_mode = 0;

    // Reset mid-burst
    t = 0; while (!(RREADY && beat == 10 && bq.size() > 0) && t < 5000) begin tick(); t++; end
    chk("E_reach_timeout", 64'(t < 5000), 1);
    rst = 1'b1;
    #1;
    chk("E_state", state, 0);          chk("E_arvalid", ARVALID, 0);
    chk("E_araddr", ARADDR, 0);        chk("E_rready", RREADY, 0);
    chk("E_m_valid", m_valid, 0);      chk("E_frame_last", m_frame_last, 0);
    chk("E_done", reader_done, 0);     chk("E_rresp_err", rresp_err, 0);
    tick(); tick();
    rst = 1'b0; a0 = ar_cnt;
    repeat (50) tick();
    chk("E_no_ar_after_rst", ar_cnt - a0, 0);
    chk("E_idle", state, 0);
    start_frame(32'h5000_0000);
    t = 0; while (ar_cnt == a0 && t < 200) begin tick(); t++; end
    chk("E_restart_araddr", last_araddr, 32'h5000_0000);
    t = 0; while (pop_idx < 64 && t < 2000) begin tick(); t++; end
    chk("E_restart_words", 64'(pop_idx >= 64), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
